// File: rtl/my_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | my_pkg : shared router constants, port codes and helpers          |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package my_pkg;

  localparam int PACKET_LENGTH = 16;
  localparam int NUM_PORTS     = 5;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    NORTH = 3'd2,
    WEST  = 3'd3,
    SOUTH = 3'd4
  } port_e;

  // Requests coming back from the port we drive would be U-turns.
  function automatic logic [NUM_PORTS-1:0] port_mask(input port_e dir);
    return (dir == LOCAL) ? '0 : (NUM_PORTS'(1) << dir);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : N-way round-robin arbiter, pointer after last winner |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [N-1:0] ereq,
  input  logic         enable,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] c_LAST = PTR_W'(N - 1);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic             w_found;

  // Scan backwards so the requester closest to the pointer is written last.
  always_comb begin
    int idx;
    w_win   = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (ereq[idx]) begin
        w_win   = PTR_W'(idx);
        w_found = 1'b1;
      end
    end
    grant = '0;
    if (enable && w_found) grant[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_ptr <= '0;
    end else if (enable && w_found) begin
      r_ptr <= (w_win == c_LAST) ? '0 : w_win + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_output.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_output : mesh router output port, RR arbiter + 2-entry skid|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module router_output
  import my_pkg::*;
#(
  parameter port_e DIR = LOCAL
) (
  input  logic                                           clk,
  input  logic                                           arst_n,
  input  logic [NUM_PORTS-1:0]                           req,
  input  logic signed [NUM_PORTS-1:0][PACKET_LENGTH-1:0] data_in,
  output logic [NUM_PORTS-1:0]                           grant,
  output logic                                           packet_valid,
  output logic signed [PACKET_LENGTH-1:0]                down,
  input  logic                                           is_reading,
  output logic [1:0]                                     occupancy
);

  localparam logic [NUM_PORTS-1:0] c_MASK = port_mask(DIR);

  logic [NUM_PORTS-1:0]              w_ereq;
  logic                              w_enable;
  logic                              w_push;
  logic                              w_pop;
  logic signed [PACKET_LENGTH-1:0]   w_push_data;

  logic signed [PACKET_LENGTH-1:0]   r_slot [2];
  logic                              r_rd_ptr;
  logic                              r_wr_ptr;
  logic [1:0]                        r_occ;

  assign w_ereq   = req & ~c_MASK;
  // Grant is held off while in reset so an asserted req cannot leak through.
  assign w_enable = arst_n && (r_occ != 2'd2);

  rr_arbiter #(.N(NUM_PORTS)) u_arb (
    .clk    (clk),
    .arst_n (arst_n),
    .ereq   (w_ereq),
    .enable (w_enable),
    .grant  (grant)
  );

  assign w_push = |grant;
  assign w_pop  = (r_occ != 2'd0) && is_reading;

  always_comb begin
    w_push_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) w_push_data = data_in[i];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_slot[0] <= '0;
      r_slot[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_occ     <= 2'd0;
    end else begin
      if (w_push) begin
        r_slot[r_wr_ptr] <= w_push_data;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign packet_valid = (r_occ != 2'd0);
  assign down         = r_slot[r_rd_ptr];
  assign occupancy    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_router_output.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_router_output : EAST/LOCAL/WEST instances vs queue-based model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_router_output;
  import my_pkg::*;

  localparam int W = PACKET_LENGTH;

  logic                           clk = 1'b0;
  logic                           arst_n = 1'b0;
  logic [4:0]                     req = '0;
  logic signed [4:0][W-1:0]       data_in = '0;
  logic                           is_reading = 1'b0;

  logic [4:0]          g_o [3];
  logic                pv_o [3];
  logic signed [W-1:0] dn_o [3];
  logic [1:0]          oc_o [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  router_output #(.DIR(EAST)) u_east (
    .clk(clk), .arst_n(arst_n), .req(req), .data_in(data_in), .grant(g_o[0]),
    .packet_valid(pv_o[0]), .down(dn_o[0]), .is_reading(is_reading), .occupancy(oc_o[0]));
  router_output #(.DIR(LOCAL)) u_local (
    .clk(clk), .arst_n(arst_n), .req(req), .data_in(data_in), .grant(g_o[1]),
    .packet_valid(pv_o[1]), .down(dn_o[1]), .is_reading(is_reading), .occupancy(oc_o[1]));
  router_output #(.DIR(WEST)) u_west (
    .clk(clk), .arst_n(arst_n), .req(req), .data_in(data_in), .grant(g_o[2]),
    .packet_valid(pv_o[2]), .down(dn_o[2]), .is_reading(is_reading), .occupancy(oc_o[2]));

  // Reference model: a packet queue and a "next to look at" index per instance.
  int         dirs [3] = '{1, 0, 3};
  logic [W-1:0] m_q [3][$];
  int         m_ptr [3];

  typedef struct {
    logic [4:0]   req;
    logic         rd;
    logic [W-1:0] pkt;
    logic [4:0]   g;
    logic         pv;
    logic [1:0]   occ;
    logic [W-1:0] dn;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_grant(input int n);
    int idx;
    if (m_q[n].size() >= 2) return 5'b0;
    for (int k = 0; k < 5; k++) begin
      idx = (m_ptr[n] + k) % 5;
      if (req[idx] && !(dirs[n] != 0 && idx == dirs[n])) return 5'b1 << idx;
    end
    return 5'b0;
  endfunction

  task automatic m_reset();
    for (int n = 0; n < 3; n++) begin
      m_q[n].delete();
      m_ptr[n] = 0;
    end
  endtask

  task automatic m_compare();
    for (int n = 0; n < 3; n++) begin
      check($sformatf("model_grant[%0d]", n), 32'(g_o[n]), 32'(m_grant(n)));
      check($sformatf("model_valid[%0d]", n), 32'(pv_o[n]), 32'(m_q[n].size() != 0));
      check($sformatf("model_occ[%0d]", n), 32'(oc_o[n]), 32'(m_q[n].size()));
      if (m_q[n].size() != 0)
        check($sformatf("model_down[%0d]", n), 32'($unsigned(dn_o[n])), 32'(m_q[n][0]));
    end
  endtask

  task automatic apply(input logic [4:0] r, input logic rd, input logic [W-1:0] pkt);
    req        = r;
    is_reading = rd;
    for (int i = 0; i < 5; i++) data_in[i] = W'(pkt + W'(i));
    #1;
    m_compare();
  endtask

  task automatic tick();
    logic [4:0] g [3];
    logic       pop [3];
    for (int n = 0; n < 3; n++) begin
      g[n]   = m_grant(n);
      pop[n] = (m_q[n].size() != 0) && is_reading;
    end
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      if (pop[n]) void'(m_q[n].pop_front());
      for (int i = 0; i < 5; i++) begin
        if (g[n][i]) begin
          m_q[n].push_back(data_in[i]);
          m_ptr[n] = (i + 1) % 5;
        end
      end
    end
    #1;
  endtask

  initial begin
    // Reset then single packet, full 1F sweep, fill/stall/drain with overlap.
    tbl[0]  = '{5'b00100, 1'b1, 16'h00A3, 5'b00100, 1'b0, 2'd0, 16'h0000};
    tbl[1]  = '{5'b00000, 1'b1, 16'h0000, 5'b00000, 1'b1, 2'd1, 16'h00A5};
    tbl[2]  = '{5'b00000, 1'b1, 16'h0000, 5'b00000, 1'b0, 2'd0, 16'h0000};
    tbl[3]  = '{5'b11111, 1'b1, 16'h0100, 5'b01000, 1'b0, 2'd0, 16'h0000};
    tbl[4]  = '{5'b11111, 1'b1, 16'h0200, 5'b10000, 1'b1, 2'd1, 16'h0103};
    tbl[5]  = '{5'b11111, 1'b1, 16'h0300, 5'b00001, 1'b1, 2'd1, 16'h0204};
    tbl[6]  = '{5'b11111, 1'b1, 16'h0400, 5'b00100, 1'b1, 2'd1, 16'h0300};
    tbl[7]  = '{5'b11111, 1'b1, 16'h0500, 5'b01000, 1'b1, 2'd1, 16'h0402};
    tbl[8]  = '{5'b00000, 1'b1, 16'h0600, 5'b00000, 1'b1, 2'd1, 16'h0503};
    tbl[9]  = '{5'b00000, 1'b1, 16'h0000, 5'b00000, 1'b0, 2'd0, 16'h0000};
    tbl[10] = '{5'b00001, 1'b0, 16'h0700, 5'b00001, 1'b0, 2'd0, 16'h0000};
    tbl[11] = '{5'b00001, 1'b0, 16'h0800, 5'b00001, 1'b1, 2'd1, 16'h0700};
    tbl[12] = '{5'b00001, 1'b0, 16'h0900, 5'b00000, 1'b1, 2'd2, 16'h0700};
    tbl[13] = '{5'b00001, 1'b1, 16'h0A00, 5'b00000, 1'b1, 2'd2, 16'h0700};
    tbl[14] = '{5'b00001, 1'b1, 16'h0B00, 5'b00001, 1'b1, 2'd1, 16'h0800};
    tbl[15] = '{5'b00000, 1'b1, 16'h0000, 5'b00000, 1'b1, 2'd1, 16'h0B00};
    tbl[16] = '{5'b00000, 1'b1, 16'h0000, 5'b00000, 1'b0, 2'd0, 16'h0000};

    // Reset with requests pending: nothing may be granted.
    req = 5'b11111;
    is_reading = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", 32'(g_o[0]), 32'h0);
    check("rst_valid", 32'(pv_o[0]), 32'h0);
    check("rst_down", 32'($unsigned(dn_o[0])), 32'h0);
    check("rst_occ", 32'(oc_o[0]), 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    req = '0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 17; v++) begin
      apply(tbl[v].req, tbl[v].rd, tbl[v].pkt);
      check($sformatf("tbl%0d_grant", v), 32'(g_o[0]), 32'(tbl[v].g));
      check($sformatf("tbl%0d_valid", v), 32'(pv_o[0]), 32'(tbl[v].pv));
      check($sformatf("tbl%0d_occ", v), 32'(oc_o[0]), 32'(tbl[v].occ));
      if (tbl[v].pv)
        check($sformatf("tbl%0d_down", v), 32'($unsigned(dn_o[0])), 32'(tbl[v].dn));
      tick();
    end

    // WEST instance never serves its own port; LOCAL serves port 0.
    for (int c = 0; c < 3; c++) begin
      apply(5'b01000, 1'b1, 16'h0C00);
      check("west_uturn_grant", 32'(g_o[2]), 32'h0);
      check("west_uturn_valid", 32'(pv_o[2]), 32'h0);
      tick();
    end
    apply(5'b00000, 1'b1, 16'h0);
    tick();
    apply(5'b00001, 1'b1, 16'h0D00);
    check("local_grant", 32'(g_o[1]), 32'h1);
    tick();

    // Fill to two entries, then reset asynchronously in the middle of a cycle.
    apply(5'b00001, 1'b0, 16'h0E00);
    tick();
    apply(5'b00001, 1'b0, 16'h0F00);
    tick();
    apply(5'b00001, 1'b0, 16'h1000);
    check("pre_rst_occ", 32'(oc_o[0]), 32'h2);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_valid", 32'(pv_o[0]), 32'h0);
    check("arst_down", 32'($unsigned(dn_o[0])), 32'h0);
    check("arst_grant", 32'(g_o[0]), 32'h0);
    check("arst_occ", 32'(oc_o[0]), 32'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    apply(5'b11110, 1'b1, 16'h1100);
    check("post_rst_first_grant_e", 32'(g_o[0]), 32'h04);
    check("post_rst_first_grant_w", 32'(g_o[2]), 32'h02);
    tick();

    // Random traffic against the queue model.
    for (int c = 0; c < 500; c++) begin
      apply(5'($urandom), ($urandom_range(0, 3) != 0), W'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
